// File: rtl/qdiv_pkg.sv
// rtl/qdiv_pkg.sv - shared widths, limits and state encoding for the serial fixed-point divider
package qdiv_pkg;

    localparam int QDIV_N  = 32;
    localparam int QDIV_Q  = 15;
    localparam int ITER    = QDIV_N + QDIV_Q - 1;
    localparam logic [QDIV_N-2:0] MAG_MAX = '1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } qdiv_state_t;

endpackage

// File: rtl/qdiv_serial.sv
// rtl/qdiv_serial.sv - sign-magnitude Q(N-Q).Q restoring divider, one quotient bit per clock
// Define QDIV_ROUND_EN to round the quotient to nearest instead of truncating toward zero.
module qdiv_serial
    import qdiv_pkg::*;
#(
    parameter int N = QDIV_N,
    parameter int Q = QDIV_Q
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [N-1:0] i_dividend,
    input  logic [N-1:0] i_divisor,
    input  logic         i_start,
    output logic [N-1:0] o_quotient_out,
    output logic         o_complete,
    output logic         o_overflow
);

    localparam int QW = N - 1 + Q;
    localparam int CW = $clog2(QW + 1);

    qdiv_state_t    state, state_nxt;
    logic [CW-1:0]  cnt;
    logic [QW-1:0]  quo;
    logic [N-2:0]   rem;
    logic [N-2:0]   dvs;
    logic           sign;
    logic           last;

    logic [N-1:0]   rem_sh;
    logic           take;
    logic [N-2:0]   rem_nxt;
    logic [QW-1:0]  quo_nxt;

    logic [QW:0]    quo_fin;
    logic           ovf_fin;
    logic [N-2:0]   mag_fin;
    logic           sign_fin;

    assign last       = (cnt == CW'(QW));
    assign o_complete = (state == IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_start) state_nxt = BUSY;
            BUSY:    if (last)    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Remainder stays below the divisor, so N-1 bits hold it; the shifted-out MSB forces a subtract.
    always_comb begin
        rem_sh  = {rem, quo[QW-1]};
        take    = rem_sh[N-1] | (rem_sh[N-2:0] >= dvs);
        rem_nxt = take ? (rem_sh[N-2:0] - dvs) : rem_sh[N-2:0];
        quo_nxt = {quo[QW-2:0], take};
    end

    always_comb begin
`ifdef QDIV_ROUND_EN
        quo_fin = {1'b0, quo} + (QW+1)'({rem, 1'b0} >= {1'b0, dvs});
`else
        quo_fin = {1'b0, quo};
`endif
        ovf_fin  = (|quo_fin[QW:N-1]) | (dvs == '0);
        mag_fin  = ovf_fin ? MAG_MAX[N-2:0] : quo_fin[N-2:0];
        sign_fin = sign & (|mag_fin);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt            <= '0;
            quo            <= '0;
            rem            <= '0;
            dvs            <= '0;
            sign           <= 1'b0;
            o_quotient_out <= '0;
            o_overflow     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        quo  <= {i_dividend[N-2:0], {Q{1'b0}}};
                        rem  <= '0;
                        dvs  <= i_divisor[N-2:0];
                        sign <= i_dividend[N-1] ^ i_divisor[N-1];
                        cnt  <= '0;
                    end
                end
                BUSY: begin
                    if (!last) begin
                        quo <= quo_nxt;
                        rem <= rem_nxt;
                        cnt <= cnt + 1'b1;
                    end else begin
                        o_quotient_out <= {sign_fin, mag_fin};
                        o_overflow     <= ovf_fin;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_qdiv_serial.sv
// tb/tb_qdiv_serial.sv - directed self-checking bench for qdiv_serial
module tb_qdiv_serial;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        start;
    logic [31:0] quotient;
    logic        complete;
    logic        overflow;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef QDIV_ROUND_EN
    localparam logic [31:0] THIRD = 32'h0000_2AAB;
`else
    localparam logic [31:0] THIRD = 32'h0000_2AAA;
`endif

    qdiv_serial dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_dividend     (dividend),
        .i_divisor      (divisor),
        .i_start        (start),
        .o_quotient_out (quotient),
        .o_complete     (complete),
        .o_overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic ov, output int lat);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (complete) begin
                lat = i;
                break;
            end
        end
        q  = quotient;
        ov = overflow;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        #1;
        n_tests++; if (complete !== 1'b1) begin n_fail++; $display("FAIL reset_complete got %b want 1", complete); end
        n_tests++; if (quotient !== 32'h0) begin n_fail++; $display("FAIL reset_quotient got %h want 00000000", quotient); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b want 0", overflow); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_unity;
        logic [31:0] q; logic ov; int lat;
        run_div(32'h0000_0384, 32'h0000_0384, q, ov, lat);
        n_tests++; if (q !== 32'h0000_8000) begin n_fail++; $display("FAIL unity_q got %h want 00008000", q); end
        n_tests++; if (ov !== 1'b0) begin n_fail++; $display("FAIL unity_ov got %b want 0", ov); end
        n_tests++; if (lat !== 47) begin n_fail++; $display("FAIL unity_latency got %0d want 47", lat); end
    endtask

    task automatic test_fraction_sign;
        logic [31:0] q; logic ov; int lat;
        run_div(32'h8001_8000, 32'h0001_0000, q, ov, lat);
        n_tests++; if (q !== 32'h8000_C000) begin n_fail++; $display("FAIL neg_frac_q got %h want 8000c000", q); end
        n_tests++; if (ov !== 1'b0) begin n_fail++; $display("FAIL neg_frac_ov got %b want 0", ov); end
        run_div(32'h0001_8000, 32'h0001_0000, q, ov, lat);
        n_tests++; if (q !== 32'h0000_C000) begin n_fail++; $display("FAIL pos_frac_q got %h want 0000c000", q); end
        run_div(32'h0001_8000, 32'h8001_0000, q, ov, lat);
        n_tests++; if (q !== 32'h8000_C000) begin n_fail++; $display("FAIL negdiv_frac_q got %h want 8000c000", q); end
    endtask

    task automatic test_rounding;
        logic [31:0] q; logic ov; int lat;
        run_div(32'h0000_8000, 32'h0001_8000, q, ov, lat);
        n_tests++; if (q !== THIRD) begin n_fail++; $display("FAIL third_q got %h want %h", q, THIRD); end
        n_tests++; if (lat !== 47) begin n_fail++; $display("FAIL third_latency got %0d want 47", lat); end
    endtask

    task automatic test_back_to_back;
        int c1, c2;
        logic [31:0] q1;
        dividend = 32'h0001_8000;
        divisor  = 32'h0001_0000;
        start    = 1'b1;
        @(posedge clk); #1;
        c1 = -1;
        for (int i = 1; i <= 100; i++) begin
            if (i == 20) begin
                dividend = 32'h0000_8000;
                divisor  = 32'h0001_8000;
            end
            @(posedge clk); #1;
            if (complete) begin c1 = i; break; end
        end
        q1 = quotient;
        n_tests++; if (c1 !== 47) begin n_fail++; $display("FAIL b2b_first_latency got %0d want 47", c1); end
        n_tests++; if (q1 !== 32'h0000_C000) begin n_fail++; $display("FAIL b2b_first_q got %h want 0000c000", q1); end
        @(posedge clk); #1;
        n_tests++; if (complete !== 1'b0) begin n_fail++; $display("FAIL b2b_complete_width got %b want 0", complete); end
        start    = 1'b0;
        dividend = 32'h7FFF_FFFF;
        divisor  = 32'h0000_0001;
        c2 = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (complete) begin c2 = i; break; end
        end
        n_tests++; if (c2 !== 47) begin n_fail++; $display("FAIL b2b_second_latency got %0d want 47", c2); end
        n_tests++; if (quotient !== THIRD) begin n_fail++; $display("FAIL b2b_second_q got %h want %h", quotient, THIRD); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL b2b_second_ov got %b want 0", overflow); end
    endtask

    task automatic test_saturation;
        logic [31:0] q; logic ov; int lat;
        run_div(32'h7FFF_FFFF, 32'h0000_0001, q, ov, lat);
        n_tests++; if (q !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL big_q got %h want 7fffffff", q); end
        n_tests++; if (ov !== 1'b1) begin n_fail++; $display("FAIL big_ov got %b want 1", ov); end
        run_div(32'h8000_0000, 32'h0000_8000, q, ov, lat);
        n_tests++; if (q !== 32'h0000_0000) begin n_fail++; $display("FAIL negzero_q got %h want 00000000", q); end
        n_tests++; if (ov !== 1'b0) begin n_fail++; $display("FAIL negzero_ov got %b want 0", ov); end
        run_div(32'h0001_8000, 32'h0000_0000, q, ov, lat);
        n_tests++; if (q !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL divzero_q got %h want 7fffffff", q); end
        n_tests++; if (ov !== 1'b1) begin n_fail++; $display("FAIL divzero_ov got %b want 1", ov); end
        n_tests++; if (lat !== 47) begin n_fail++; $display("FAIL divzero_latency got %0d want 47", lat); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] q; logic ov; int lat;
        dividend = 32'h8001_8000;
        divisor  = 32'h0001_0000;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        n_tests++; if (complete !== 1'b1) begin n_fail++; $display("FAIL midrst_complete got %b want 1", complete); end
        n_tests++; if (quotient !== 32'h0) begin n_fail++; $display("FAIL midrst_quotient got %h want 00000000", quotient); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL midrst_overflow got %b want 0", overflow); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_div(32'h0001_8000, 32'h0001_0000, q, ov, lat);
        n_tests++; if (q !== 32'h0000_C000) begin n_fail++; $display("FAIL postrst_q got %h want 0000c000", q); end
        n_tests++; if (lat !== 47) begin n_fail++; $display("FAIL postrst_latency got %0d want 47", lat); end
    endtask

    initial begin
        test_reset();
        test_unity();
        test_fraction_sign();
        test_rounding();
        test_back_to_back();
        test_saturation();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
